evo_pipeline_core: RTL and testbench
====================================

Name: evo_pipeline_core

Overview:
- Parametrised three-stage in-order datapath (issue/read, execute, memory/writeback) for the Evo processor family.
- Contains a register file, ALU and data memory behind an in_valid/in_ready handshake.
- Adds load-immediate, stall control, result forwarding and a stall counter.
- Sits between the instruction source and the debug/output bus; output_data holds the last written-back value.

Parameters:
- DATA_WIDTH, 32: register, ALU and memory word width.
- REG_ADDR_WIDTH, 5: register index width. 2**REG_ADDR_WIDTH registers; r0 always reads zero.
- MEM_ADDR_WIDTH, 6: data memory depth is 2**MEM_ADDR_WIDTH words.
- STALL_CNT_WIDTH, 16: stall counter width.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  core accepts instruction this cycle.
- instruction  in  3+3*REG_ADDR_WIDTH  fields {op[2:0], dst, src1, src2}.
- wb_valid  out  1  register write occurring this cycle.
- wb_addr  out  REG_ADDR_WIDTH  destination of the write.
- wb_data  out  DATA_WIDTH  value being written.
- output_data  out  DATA_WIDTH  last written-back value (registered).
- stall_count  out  STALL_CNT_WIDTH  saturating count of stall cycles.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (clock, reset_n).
- Reset values:
  - Registers r0..rN and all stage valid bits clear to 0; in-flight instructions are dropped.
  - in_ready=1, wb_valid=0, wb_addr=0, wb_data=0, output_data=0, stall_count=0.
  - Data memory is not reset.
- Opcodes:
  - 000 ADD: dst=src1+src2.
  - 001 SUB: dst=src1-src2.
  - 010 AND.
  - 011 OR.
  - 100 LI: dst=zero-extended {src1,src2} field.
  - 101 LOAD: dst=mem[src1 low MEM_ADDR_WIDTH bits].
  - 110 STORE: mem[src1 low bits]=src2; no register write.
  - 111 NOP.
- Arithmetic: modulo 2**DATA_WIDTH; no flags. Memory address wraps via truncation.
- Handshake and latency: accept on edge where in_valid&&in_ready.
  - Accept edge k: sources read/forwarded and latched into EX.
  - Edge k+1: EX result latched into WB.
  - Cycle k+1..k+2: wb_valid/wb_addr/wb_data driven combinationally from WB.
  - Edge k+2: register file write, memory write (STORE) and output_data update occur.
- wb_valid=1 only for ADD/SUB/AND/OR/LI/LOAD with dst!=0. Writes to r0 are discarded and output_data is unchanged.
- Memory access:
  - LOAD reads memory combinationally in WB.
  - STORE immediately followed by LOAD to the same address returns the stored value; no hazard.
- Register file is write-through: a read of the register WB is writing in the same cycle returns the new value.
- Hazards with forwarding:
  - EX holds an ALU/LI op whose dst (non-zero) matches a source of the incoming instruction: the EX result is forwarded, no stall.
  - EX holds a LOAD with a matching dst: in_ready=0 for exactly one cycle, then issue.
- A source index of 0 never causes a stall or a forward.
- Stall accounting: stall_count increments on each cycle with in_valid=1 and in_ready=0, and saturates at all-ones.
- Bubbles: in_valid=0 inserts a bubble and the pipeline drains normally. in_ready depends only on the EX stage, never on in_valid.
- Reset asserted mid-stream: the next edge clears everything; no write from dropped instructions occurs.

Optional Feature:
- FORWARDING_EN defined: forwarding as described; only a LOAD-use stall of 1 cycle.
- FORWARDING_EN undefined: no EX forward path. Any non-zero source matching an EX-stage register-writing dst stalls 1 cycle; WB coverage comes from write-through.
- Results identical in both builds; only stall timing and stall_count differ.

Decomposition:
- Package evo_pkg:
  - Opcode enum.
  - INSTR_WIDTH/IMM_WIDTH localparam functions of REG_ADDR_WIDTH.
  - Decoded-instruction struct {op, dst, src1, src2, writes_reg, is_load}.
- Sub-module evo_regfile: parametrised, two combinational read ports, one write port, write-through, r0 hardwired zero, synchronous active-low clear.
- ALU, hazard logic and memory stay in evo_pipeline_core.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles -> in_ready=1, wb_valid=0, output_data=0, stall_count=0.
- LI r1,5; LI r2,3; ADD r3,r1,r2 back-to-back -> no stall; wb_addr=3, wb_data=8 two cycles after ADD accepted; output_data=8.
- SUB r4,r2,r1 (3-5) -> wb_data=0xFFFFFFFE.
- STORE mem[r1]=r3; LOAD r5,[r1]; ADD r6,r5,r5:
  - in_ready=0 for exactly one cycle before ADD; r6=16; stall_count=1.
- LI r0,7; ADD r7,r0,r0:
  - wb_valid=0 for LI; r7=0; output_data unchanged by the LI.
- Build without FORWARDING_EN: LI r1,5; ADD r2,r1,r1 -> one stall; r2=10; reset asserted while ADD is in EX -> no write of r2, all outputs 0.

Source files
------------

// File: rtl/evo_pkg.sv
// Shared types for the Evo pipeline core: opcodes, instruction geometry and decode.
package evo_pkg;

    typedef enum logic [2:0] {
        OpAdd   = 3'b000,
        OpSub   = 3'b001,
        OpAnd   = 3'b010,
        OpOr    = 3'b011,
        OpLi    = 3'b100,
        OpLoad  = 3'b101,
        OpStore = 3'b110,
        OpNop   = 3'b111
    } op_e;

    function automatic int unsigned instr_width(input int unsigned reg_addr_width);
        return 3 + 3 * reg_addr_width;
    endfunction

    function automatic int unsigned imm_width(input int unsigned reg_addr_width);
        return 2 * reg_addr_width;
    endfunction

    // Decoded fields are sized for the family's register index width.
    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned INSTR_WIDTH = instr_width(REG_ADDR_W);
    localparam int unsigned IMM_WIDTH   = imm_width(REG_ADDR_W);

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

    typedef struct packed {
        op_e      op;
        reg_idx_t dst;
        reg_idx_t src1;
        reg_idx_t src2;
        logic     writes_reg;
        logic     is_load;
    } decoded_t;

    function automatic decoded_t decode(input logic [INSTR_WIDTH-1:0] instr);
        decoded_t d;
        d.op         = op_e'(instr[INSTR_WIDTH-1 -: 3]);
        d.dst        = instr[3*REG_ADDR_W-1 -: REG_ADDR_W];
        d.src1       = instr[2*REG_ADDR_W-1 -: REG_ADDR_W];
        d.src2       = instr[REG_ADDR_W-1:0];
        // r0 destinations are folded in here so hazards never see them
        d.writes_reg = (d.op inside {OpAdd, OpSub, OpAnd, OpOr, OpLi, OpLoad}) && (d.dst != '0);
        d.is_load    = (d.op == OpLoad);
        return d;
    endfunction

    function automatic logic uses_src1(input op_e op);
        return op inside {OpAdd, OpSub, OpAnd, OpOr, OpLoad, OpStore};
    endfunction

    function automatic logic uses_src2(input op_e op);
        return op inside {OpAdd, OpSub, OpAnd, OpOr, OpStore};
    endfunction

endpackage

// File: rtl/evo_pipeline_core_if.sv
// Instruction handshake and writeback/debug bus of the Evo pipeline core.
interface evo_pipeline_core_if
    import evo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned REG_ADDR_WIDTH  = 5,
    parameter int unsigned STALL_CNT_WIDTH = 16
);
    logic                                   in_valid;
    logic                                   in_ready;
    logic [instr_width(REG_ADDR_WIDTH)-1:0] instruction;
    logic                                   wb_valid;
    logic [REG_ADDR_WIDTH-1:0]              wb_addr;
    logic [DATA_WIDTH-1:0]                  wb_data;
    logic [DATA_WIDTH-1:0]                  output_data;
    logic [STALL_CNT_WIDTH-1:0]             stall_count;

    modport master (
        output in_valid, instruction,
        input  in_ready, wb_valid, wb_addr, wb_data, output_data, stall_count
    );

    modport slave (
        input  in_valid, instruction,
        output in_ready, wb_valid, wb_addr, wb_data, output_data, stall_count
    );
endinterface

// File: rtl/evo_regfile.sv
// Register file: two combinational write-through read ports, one write port, r0 reads zero.
module evo_regfile #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] raddr_a,
    output logic [DATA_WIDTH-1:0] rdata_a,
    input  logic [ADDR_WIDTH-1:0] raddr_b,
    output logic [DATA_WIDTH-1:0] rdata_b,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata
);
    logic [DATA_WIDTH-1:0] regs_q [1 << ADDR_WIDTH];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < (1 << ADDR_WIDTH); i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_a = regs_q[raddr_a];
        if (raddr_a == '0) begin
            rdata_a = '0;
        end else if (we && (waddr == raddr_a)) begin
            rdata_a = wdata;
        end
        rdata_b = regs_q[raddr_b];
        if (raddr_b == '0) begin
            rdata_b = '0;
        end else if (we && (waddr == raddr_b)) begin
            rdata_b = wdata;
        end
    end
endmodule

// File: rtl/evo_pipeline_core.sv
// Three-stage Evo datapath (issue, execute, memory/writeback) with LOAD-use hazard control.
// Build option FORWARDING_EN enables the EX-to-issue forward path.
module evo_pipeline_core
    import evo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned REG_ADDR_WIDTH  = REG_ADDR_W,
    parameter int unsigned MEM_ADDR_WIDTH  = 6,
    parameter int unsigned STALL_CNT_WIDTH = 16
) (
    input logic                clock,
    input logic                reset_n,
    evo_pipeline_core_if.slave bus
);
    decoded_t              id_dec;
    logic [DATA_WIDTH-1:0] rs1_data, rs2_data, op_a, op_b;
    logic                  hit_src1, hit_src2, stall, accept;

    logic                  ex_valid_q;
    decoded_t              ex_dec_q;
    logic [DATA_WIDTH-1:0] ex_a_q, ex_b_q, ex_result;
    logic [IMM_WIDTH-1:0]  ex_imm;

    logic                  wb_writes_q, wb_is_load_q, wb_is_store_q;
    reg_idx_t              wb_dst_q;
    logic [DATA_WIDTH-1:0] wb_result_q, wb_store_q, wb_data;
    logic [DATA_WIDTH-1:0] output_data_q;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_q;

    logic [DATA_WIDTH-1:0]     mem_q [1 << MEM_ADDR_WIDTH];
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;

    assign id_dec = decode(bus.instruction);

    evo_regfile #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_regfile (
        .clock  (clock),
        .reset_n(reset_n),
        .raddr_a(id_dec.src1),
        .rdata_a(rs1_data),
        .raddr_b(id_dec.src2),
        .rdata_b(rs2_data),
        .we     (wb_writes_q),
        .waddr  (wb_dst_q),
        .wdata  (wb_data)
    );

    // Hazards look only at EX; a WB-stage producer is covered by regfile write-through.
    always_comb begin
        hit_src1 = ex_valid_q && ex_dec_q.writes_reg && uses_src1(id_dec.op) &&
                   (id_dec.src1 == ex_dec_q.dst);
        hit_src2 = ex_valid_q && ex_dec_q.writes_reg && uses_src2(id_dec.op) &&
                   (id_dec.src2 == ex_dec_q.dst);
        op_a     = rs1_data;
        op_b     = rs2_data;
`ifdef FORWARDING_EN
        stall = (hit_src1 || hit_src2) && ex_dec_q.is_load;
        if (hit_src1) op_a = ex_result;
        if (hit_src2) op_b = ex_result;
`else
        stall = hit_src1 || hit_src2;
`endif
    end

    assign accept = bus.in_valid && !stall;
    assign ex_imm = {ex_dec_q.src1, ex_dec_q.src2};

    always_comb begin
        unique case (ex_dec_q.op)
            OpAdd:           ex_result = ex_a_q + ex_b_q;
            OpSub:           ex_result = ex_a_q - ex_b_q;
            OpAnd:           ex_result = ex_a_q & ex_b_q;
            OpOr:            ex_result = ex_a_q | ex_b_q;
            OpLi:            ex_result = DATA_WIDTH'(ex_imm);
            OpLoad, OpStore: ex_result = ex_a_q;  // memory address travels in the result slot
            default:         ex_result = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ex_valid_q    <= 1'b0;
            ex_dec_q      <= '0;
            ex_a_q        <= '0;
            ex_b_q        <= '0;
            wb_writes_q   <= 1'b0;
            wb_is_load_q  <= 1'b0;
            wb_is_store_q <= 1'b0;
            wb_dst_q      <= '0;
            wb_result_q   <= '0;
            wb_store_q    <= '0;
            output_data_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            ex_valid_q <= accept;
            if (accept) begin
                ex_dec_q <= id_dec;
                ex_a_q   <= op_a;
                ex_b_q   <= op_b;
            end
            wb_writes_q   <= ex_valid_q && ex_dec_q.writes_reg;
            wb_is_load_q  <= ex_valid_q && ex_dec_q.is_load;
            wb_is_store_q <= ex_valid_q && (ex_dec_q.op == OpStore);
            wb_dst_q      <= ex_dec_q.dst;
            wb_result_q   <= ex_result;
            wb_store_q    <= ex_b_q;
            if (wb_writes_q) begin
                output_data_q <= wb_data;
            end
            if (bus.in_valid && stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign mem_addr = wb_result_q[MEM_ADDR_WIDTH-1:0];

    always_ff @(posedge clock) begin
        if (reset_n && wb_is_store_q) begin
            mem_q[mem_addr] <= wb_store_q;
        end
    end

    assign wb_data         = wb_is_load_q ? mem_q[mem_addr] : wb_result_q;
    assign bus.in_ready    = !stall;
    assign bus.wb_valid    = wb_writes_q;
    assign bus.wb_addr     = wb_dst_q;
    assign bus.wb_data     = wb_data;
    assign bus.output_data = output_data_q;
    assign bus.stall_count = stall_cnt_q;
endmodule

// File: tb/tb_evo_pipeline_core.sv
// Bench for evo_pipeline_core: architectural model plus per-cycle compare, with literal anchors.
module tb_evo_pipeline_core;
    localparam int DW  = 32;
    localparam int RAW = 5;
    localparam int MAW = 6;
    localparam int SCW = 16;
`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    evo_pipeline_core_if #(
        .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RAW), .STALL_CNT_WIDTH(SCW)
    ) bus ();

    evo_pipeline_core #(
        .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RAW), .MEM_ADDR_WIDTH(MAW), .STALL_CNT_WIDTH(SCW)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] enc(input logic [2:0] op, input logic [4:0] d,
                                        input logic [4:0] s1, input logic [4:0] s2);
        return {op, d, s1, s2};
    endfunction

    // Architectural model: instructions take effect in order at acceptance.
    typedef struct {
        int          due;
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_t;

    logic [31:0] m_regs [32];
    logic [31:0] m_mem  [64];
    wb_t         exp_q  [$];
    wb_t         e;
    logic [31:0] m_out;
    int          m_stall;
    int          cyc   = 0;
    int          n_acc = 0;
    bit          armed = 1'b0;
    bit          last_acc = 1'b0;
    logic [17:0] last_ins;
    bit          rdy, exp_wb;

    function automatic bit pred_ready(input logic [17:0] ins);
        logic [2:0] pop, op;
        logic [4:0] pdst, s1, s2;
        bit         u1, u2;
        pop  = last_ins[17:15];
        pdst = last_ins[14:10];
        op   = ins[17:15];
        s1   = ins[9:5];
        s2   = ins[4:0];
        if (!last_acc || pop > 3'd5 || pdst == 5'd0) return 1'b1;
        if (FWD && pop != 3'd5) return 1'b1;
        u1 = (op <= 3'd3) || (op == 3'd5) || (op == 3'd6);
        u2 = (op <= 3'd3) || (op == 3'd6);
        return !((u1 && s1 == pdst) || (u2 && s2 == pdst));
    endfunction

    task automatic execute(input logic [17:0] ins);
        logic [2:0]  op;
        logic [4:0]  d, s1, s2;
        logic [31:0] a, b, r;
        wb_t         w;
        op = ins[17:15]; d = ins[14:10]; s1 = ins[9:5]; s2 = ins[4:0];
        a  = m_regs[s1]; b = m_regs[s2]; r = '0;
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = {22'd0, s1, s2};
            3'd5: r = m_mem[a[5:0]];
            3'd6: m_mem[a[5:0]] = b;
            default: ;
        endcase
        if (op <= 3'd5 && d != 5'd0) begin
            m_regs[d] = r;
            w.due = cyc + 2; w.addr = d; w.data = r;
            exp_q.push_back(w);
        end
    endtask

    always @(negedge clock) begin
        rdy = pred_ready(bus.instruction);
        if (armed) begin
            check("in_ready", bus.in_ready, rdy);
            exp_wb = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            check("wb_valid", bus.wb_valid, exp_wb);
            if (exp_wb) begin
                e = exp_q.pop_front();
                check("wb_addr", bus.wb_addr, e.addr);
                check("wb_data", bus.wb_data, e.data);
            end
            check("output_data", bus.output_data, m_out);
            check("stall_count", bus.stall_count, m_stall);
            if (exp_wb) m_out = e.data;
            if (bus.in_valid && !rdy && m_stall < 65535) m_stall++;
        end
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            exp_q.delete();
            m_out    = '0;
            m_stall  = 0;
            last_acc = 1'b0;
            armed    = 1'b1;
        end else if (armed) begin
            if (bus.in_valid && rdy) begin
                execute(bus.instruction);
                n_acc++;
                last_acc = 1'b1;
                last_ins = bus.instruction;
            end else begin
                last_acc = 1'b0;
            end
        end
        cyc++;
    end

    task automatic send(input logic [2:0] op, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2);
        int target;
        bus.in_valid    = 1'b1;
        bus.instruction = enc(op, d, s1, s2);
        target = n_acc + 1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock);
            #1;
            if (n_acc >= target) break;
        end
        if (n_acc < target) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no accept, expected accept of op %0d", op);
        end
    endtask

    task automatic idle(input int n);
        bus.in_valid    = 1'b0;
        bus.instruction = enc(3'd7, 5'd0, 5'd0, 5'd0);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.instruction = enc(3'd7, 5'd0, 5'd0, 5'd0);
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_wb_valid", bus.wb_valid, 0);
        check("reset_output", bus.output_data, 0);
        check("reset_stall", bus.stall_count, 0);
        reset_n = 1'b1;

        // LI r1,5; LI r2,3; ADD r3,r1,r2
        send(3'd4, 5'd1, 5'd0, 5'd5);
        send(3'd4, 5'd2, 5'd0, 5'd3);
        send(3'd0, 5'd3, 5'd1, 5'd2);
        idle(4);
        check("add_output", bus.output_data, 32'd8);
        check("add_stalls", bus.stall_count, FWD ? 0 : 1);

        send(3'd1, 5'd4, 5'd2, 5'd1);
        idle(4);
        check("sub_output", bus.output_data, 32'hFFFF_FFFE);

        // STORE mem[r1]=r3; LOAD r5,[r1]; ADD r6,r5,r5
        send(3'd6, 5'd0, 5'd1, 5'd3);
        send(3'd5, 5'd5, 5'd1, 5'd0);
        send(3'd0, 5'd6, 5'd5, 5'd5);
        idle(4);
        check("load_use_output", bus.output_data, 32'd16);
        check("load_use_stalls", bus.stall_count, FWD ? 1 : 2);

        // Writes to r0 are discarded
        send(3'd4, 5'd0, 5'd0, 5'd7);
        idle(3);
        check("li_r0_output", bus.output_data, 32'd16);
        send(3'd0, 5'd7, 5'd0, 5'd0);
        idle(4);
        check("r0_add_output", bus.output_data, 32'd0);

        // LI r8,0x3C; LI r9,0x0F; AND/OR; LI of the largest immediate
        send(3'd4, 5'd8, 5'd1, 5'd28);
        send(3'd4, 5'd9, 5'd0, 5'd15);
        send(3'd2, 5'd10, 5'd8, 5'd9);
        send(3'd3, 5'd11, 5'd8, 5'd9);
        idle(4);
        check("or_output", bus.output_data, 32'h3F);
        send(3'd4, 5'd12, 5'd31, 5'd31);
        idle(4);
        check("li_max_output", bus.output_data, 32'h3FF);

        // A bubble between producer and consumer relies on write-through
        send(3'd4, 5'd14, 5'd0, 5'd9);
        idle(1);
        send(3'd0, 5'd15, 5'd14, 5'd14);
        idle(4);
        check("bubble_output", bus.output_data, 32'd18);

        // Reset while ADD r2 sits in EX drops it
        send(3'd4, 5'd1, 5'd0, 5'd6);
        send(3'd0, 5'd2, 5'd1, 5'd1);
        bus.in_valid = 1'b0;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        check("midreset_wb_valid", bus.wb_valid, 0);
        check("midreset_wb_data", bus.wb_data, 0);
        check("midreset_output", bus.output_data, 0);
        check("midreset_stall", bus.stall_count, 0);
        check("midreset_in_ready", bus.in_ready, 1);
        reset_n = 1'b1;
        idle(2);
        send(3'd4, 5'd3, 5'd0, 5'd1);
        send(3'd0, 5'd13, 5'd2, 5'd3);
        idle(4);
        check("post_reset_r2_cleared", bus.output_data, 32'd1);

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
